// File: rtl/ddr3_cmd_arbiter_if.sv
// Bundle of the frame-writer, frame-reader and DDR3 user-port signals around ddr3_cmd_arbiter.
// slave is the arbiter's view; master is the view of the clients and the memory IP around it.
interface ddr3_cmd_arbiter_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned LEN_W  = 16
) ();
  localparam int unsigned MASK_W = DATA_W / 8;

  logic              ddr_init_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  wr_len;
  logic              wr_gnt;
  logic              wr_data_req;
  logic [DATA_W-1:0] wr_data;
  logic              wr_done;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_gnt;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_vld;
  logic              ddr_cmd_ready;
  logic [2:0]        ddr_cmd;
  logic              ddr_cmd_en;
  logic [ADDR_W-1:0] ddr_addr;
  logic              ddr_wr_data_rdy;
  logic [DATA_W-1:0] ddr_wr_data;
  logic              ddr_wr_data_en;
  logic              ddr_wr_data_end;
  logic [MASK_W-1:0] ddr_wr_mask;
  logic [DATA_W-1:0] ddr_rd_data;
  logic              ddr_rd_data_valid;

  modport slave (
    input  ddr_init_done, wr_req, wr_addr, wr_len, wr_data,
           rd_req, rd_addr, rd_len,
           ddr_cmd_ready, ddr_wr_data_rdy, ddr_rd_data, ddr_rd_data_valid,
    output wr_gnt, wr_data_req, wr_done, rd_gnt, rd_done, rd_data, rd_data_vld,
           ddr_cmd, ddr_cmd_en, ddr_addr, ddr_wr_data, ddr_wr_data_en,
           ddr_wr_data_end, ddr_wr_mask
  );

  modport master (
    output ddr_init_done, wr_req, wr_addr, wr_len, wr_data,
           rd_req, rd_addr, rd_len,
           ddr_cmd_ready, ddr_wr_data_rdy, ddr_rd_data, ddr_rd_data_valid,
    input  wr_gnt, wr_data_req, wr_done, rd_gnt, rd_done, rd_data, rd_data_vld,
           ddr_cmd, ddr_cmd_en, ddr_addr, ddr_wr_data, ddr_wr_data_en,
           ddr_wr_data_end, ddr_wr_mask
  );
endinterface

// File: rtl/ddr3_cmd_arbiter.sv
// Round-robin arbiter between the frame writer and frame reader, sequencing each
// multi-command transaction onto the single DDR3 user command/data channel.
module ddr3_cmd_arbiter #(
  parameter int unsigned ADDR_W    = 28,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned BEATS     = 8,
  parameter int unsigned ADDR_STEP = 64,
  parameter int unsigned LEN_W     = 16
) (
  input logic               clk,
  input logic               rst,
  ddr3_cmd_arbiter_if.slave bus
);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam logic [2:0]  CMD_WR = 3'b000;
  localparam logic [2:0]  CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_CMD, S_WR_DATA, S_RD_CMD, S_RD_WAIT, S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remain;
  logic [BEAT_W-1:0] beat;
  logic              last_rd;
  logic              wr_gnt_q;
  logic              rd_gnt_q;
  logic              wr_done_q;
  logic              rd_done_q;
  logic              rd_vld_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [2:0]        cmd_q;

  logic in_cmd;
  logic wr_beat;
  logic rd_beat;
  logic last_beat;
  logic pick_wr;
  logic pick_rd;

  // Beat qualification and round-robin pick; last_rd breaks ties toward the other port.
  always_comb begin
    in_cmd    = (state == S_WR_CMD) || (state == S_RD_CMD);
    wr_beat   = (state == S_WR_DATA) && bus.ddr_wr_data_rdy;
    rd_beat   = (state == S_RD_WAIT) && bus.ddr_rd_data_valid;
    last_beat = (beat == BEAT_W'(BEATS - 1));
    pick_wr   = bus.ddr_init_done && bus.wr_req && (!bus.rd_req || last_rd);
    pick_rd   = bus.ddr_init_done && bus.rd_req && !pick_wr;
  end

  // Command strobe and write data are pass-through so the IP handshakes add no latency.
  assign bus.ddr_cmd_en      = in_cmd && bus.ddr_cmd_ready;
  assign bus.wr_data_req     = wr_beat;
  assign bus.ddr_wr_data_en  = wr_beat;
  assign bus.ddr_wr_data_end = wr_beat;
  assign bus.ddr_wr_data     = bus.wr_data;
  assign bus.ddr_wr_mask     = MASK_W'(0);
  assign bus.ddr_addr        = cur_addr;
  assign bus.ddr_cmd         = cmd_q;
  assign bus.wr_gnt          = wr_gnt_q;
  assign bus.rd_gnt          = rd_gnt_q;
  assign bus.wr_done         = wr_done_q;
  assign bus.rd_done         = rd_done_q;
  assign bus.rd_data         = rd_data_q;
  assign bus.rd_data_vld     = rd_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remain    <= '0;
      beat      <= '0;
      last_rd   <= 1'b1;
      wr_gnt_q  <= 1'b0;
      rd_gnt_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      cmd_q     <= CMD_WR;
    end else begin
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
      rd_vld_q  <= rd_beat;
      if (rd_beat) rd_data_q <= bus.ddr_rd_data;

      unique case (state)
        S_IDLE: begin
          if (pick_wr) begin
            wr_gnt_q <= 1'b1;
            cmd_q    <= CMD_WR;
            cur_addr <= bus.wr_addr;
            remain   <= bus.wr_len;
            if (bus.wr_len == '0) begin
              wr_done_q <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_WR_CMD;
            end
          end else if (pick_rd) begin
            rd_gnt_q <= 1'b1;
            cmd_q    <= CMD_RD;
            cur_addr <= bus.rd_addr;
            remain   <= bus.rd_len;
            if (bus.rd_len == '0) begin
              rd_done_q <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_RD_CMD;
            end
          end
        end

        S_WR_CMD, S_RD_CMD: begin
          if (bus.ddr_cmd_ready) begin
            beat  <= '0;
            state <= (state == S_WR_CMD) ? S_WR_DATA : S_RD_WAIT;
          end
        end

        // Write and read bursts share the beat/address bookkeeping.
        S_WR_DATA, S_RD_WAIT: begin
          if (wr_beat || rd_beat) begin
            beat <= beat + BEAT_W'(1);
            if (last_beat) begin
              cur_addr <= cur_addr + ADDR_W'(ADDR_STEP);
              remain   <= remain - LEN_W'(1);
              if (remain == LEN_W'(1)) begin
                wr_done_q <= wr_gnt_q;
                rd_done_q <= rd_gnt_q;
                state     <= S_DONE;
              end else begin
                state <= (state == S_WR_DATA) ? S_WR_CMD : S_RD_CMD;
              end
            end
          end
        end

        S_DONE: begin
          wr_gnt_q <= 1'b0;
          rd_gnt_q <= 1'b0;
          last_rd  <= rd_gnt_q;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
